// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction decode stage with an integrated register file and an
//   ID/EX pipeline register. Decodes one RV-style 32-bit instruction per
//   cycle, reads both source operands, builds the sign-extended immediate
//   and holds the result in the ID/EX register until EX consumes it.
//   A load followed by a dependent instruction inserts one bubble.
//
// Parameters
//   XLEN       register / data / PC width (32 or 64)
//   NREG       architectural register count (16 or 32); index width is 5
//   WB_BYPASS  1: a same-cycle writeback is forwarded to the operand reads
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid/in_ready         fetch handshake, in_pc/in_inst payload
//   flush                     kills the ID/EX content and the incoming word
//   wb_en/wb_addr/wb_data     register file write port
//   out_valid/out_ready       ID/EX handshake towards EX
//   out_*                     decoded fields held in the ID/EX register
//   stall_cnt                 saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN      = 64,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            flush,

  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic            out_is_load,
  output logic [31:0]     stall_cnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  // -------------------------------------------------------------------------
  // Field extraction
  // -------------------------------------------------------------------------
  logic [6:0] dec_opcode;
  logic [4:0] dec_rd;
  logic [2:0] dec_funct3;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [6:0] dec_funct7;

  assign dec_opcode = in_inst[6:0];
  assign dec_rd     = in_inst[11:7];
  assign dec_funct3 = in_inst[14:12];
  assign dec_rs1    = in_inst[19:15];
  assign dec_rs2    = in_inst[24:20];
  assign dec_funct7 = in_inst[31:25];

  // -------------------------------------------------------------------------
  // Register file. x0 has no storage; indices >= NREG never match an entry,
  // so they read 0 and drop writes.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] rf_q [1:NREG-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en) begin
      // Writes go through regardless of flush.
      for (int i = 1; i < NREG; i++) begin
        if (wb_addr == 5'(i)) begin
          rf_q[i] <= wb_data;
        end
      end
    end
  end

  logic            wb_fwd_ok;
  logic [XLEN-1:0] rs1_val_d;
  logic [XLEN-1:0] rs2_val_d;

  assign wb_fwd_ok = (WB_BYPASS != 0) && wb_en;

  always_comb begin
    rs1_val_d = '0;
    rs2_val_d = '0;
    for (int i = 1; i < NREG; i++) begin
      if (dec_rs1 == 5'(i)) begin
        rs1_val_d = (wb_fwd_ok && (wb_addr == dec_rs1)) ? wb_data : rf_q[i];
      end
      if (dec_rs2 == 5'(i)) begin
        rs2_val_d = (wb_fwd_ok && (wb_addr == dec_rs2)) ? wb_data : rf_q[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Immediate generation. Built as a signed 32-bit value, then the cast to
  // XLEN sign-extends it (a no-op when XLEN is 32).
  // -------------------------------------------------------------------------
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    imm_d;

  always_comb begin
    imm32 = '0;
    case (dec_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32:
        imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      OP_STORE:
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                 in_inst[30:25], in_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {in_inst[31:12], 12'b0};
      OP_JAL:
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                 in_inst[20], in_inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm_d = XLEN'(imm32);

  // -------------------------------------------------------------------------
  // Operand usage and load-use hazard
  // -------------------------------------------------------------------------
  logic uses_rs1;
  logic uses_rs2;
  logic is_load_d;
  logic hazard;
  logic advance;

  assign uses_rs1  = !((dec_opcode == OP_LUI) || (dec_opcode == OP_AUIPC) ||
                       (dec_opcode == OP_JAL));
  assign uses_rs2  = (dec_opcode == OP_OP) || (dec_opcode == OP_OP32) ||
                     (dec_opcode == OP_STORE) || (dec_opcode == OP_BRANCH);
  assign is_load_d = (dec_opcode == OP_LOAD);

  logic out_valid_q;
  logic out_is_load_q;
  logic [4:0] out_rd_q;

  assign hazard = in_valid && out_valid_q && out_is_load_q && (out_rd_q != 5'd0) &&
                  ((uses_rs1 && (out_rd_q == dec_rs1)) ||
                   (uses_rs2 && (out_rd_q == dec_rs2)));

  assign advance  = !out_valid_q || out_ready;

  // A flush always accepts (and discards) whatever is offered.
  assign in_ready = flush || (advance && !hazard);

  // -------------------------------------------------------------------------
  // ID/EX register
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] out_pc_q;
  logic [6:0]      out_opcode_q;
  logic [2:0]      out_funct3_q;
  logic [6:0]      out_funct7_q;
  logic [4:0]      out_rs1_q;
  logic [4:0]      out_rs2_q;
  logic [XLEN-1:0] out_rs1_val_q;
  logic [XLEN-1:0] out_rs2_val_q;
  logic [XLEN-1:0] out_imm_q;
  logic [31:0]     stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_funct7_q  <= '0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_rd_q      <= '0;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_imm_q     <= '0;
      out_is_load_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance && hazard) begin
      out_valid_q <= 1'b0;
      if (stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end else if (advance) begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_pc_q      <= in_pc;
        out_opcode_q  <= dec_opcode;
        out_funct3_q  <= dec_funct3;
        out_funct7_q  <= dec_funct7;
        out_rs1_q     <= dec_rs1;
        out_rs2_q     <= dec_rs2;
        out_rd_q      <= dec_rd;
        out_rs1_val_q <= rs1_val_d;
        out_rs2_val_q <= rs2_val_d;
        out_imm_q     <= imm_d;
        out_is_load_q <= is_load_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_opcode_q;
  assign out_funct3  = out_funct3_q;
  assign out_funct7  = out_funct7_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_rd      = out_rd_q;
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;
  assign out_imm     = out_imm_q;
  assign out_is_load = out_is_load_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage (XLEN=64, NREG=32). A second instance
//   with WB_BYPASS=0 shares all inputs to compare forwarding behaviour.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam int XLEN = 64;

  localparam logic [31:0] I_ADDI_X1  = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_ADD_655  = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] I_LD_X7    = 32'h00013383; // ld x7,0(x2)
  localparam logic [31:0] I_LD_X0    = 32'h00013003; // ld x0,0(x2)
  localparam logic [31:0] I_ADD_871  = 32'h00138433; // add x8,x7,x1
  localparam logic [31:0] I_ADD_11   = 32'h00A505B3; // add x11,x10,x10
  localparam logic [31:0] I_ADD_900  = 32'h000004B3; // add x9,x0,x0
  localparam logic [31:0] I_SW       = 32'h00A12623;
  localparam logic [31:0] I_BEQ      = 32'hFE000EE3;
  localparam logic [31:0] I_JAL      = 32'h0080006F;
  localparam logic [31:0] I_LUI      = 32'h123452B7;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;
  logic            flush;
  logic            wb_en;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            out_ready;

  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val, out_imm;
  logic            out_is_load;
  logic [31:0]     stall_cnt;

  logic            d2_in_ready;
  logic            d2_out_valid;
  logic [XLEN-1:0] d2_out_pc;
  logic [6:0]      d2_out_opcode;
  logic [2:0]      d2_out_funct3;
  logic [6:0]      d2_out_funct7;
  logic [4:0]      d2_out_rs1, d2_out_rs2, d2_out_rd;
  logic [XLEN-1:0] d2_out_rs1_val, d2_out_rs2_val, d2_out_imm;
  logic            d2_out_is_load;
  logic [31:0]     d2_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .NREG(32), .WB_BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  decode_stage #(.XLEN(XLEN), .NREG(32), .WB_BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(d2_in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_pc(d2_out_pc),
    .out_opcode(d2_out_opcode), .out_funct3(d2_out_funct3), .out_funct7(d2_out_funct7),
    .out_rs1(d2_out_rs1), .out_rs2(d2_out_rs2), .out_rd(d2_out_rd),
    .out_rs1_val(d2_out_rs1_val), .out_rs2_val(d2_out_rs2_val), .out_imm(d2_out_imm),
    .out_is_load(d2_out_is_load), .stall_cnt(d2_stall_cnt)
  );

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [XLEN-1:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b1;
    present(64'h100, I_ADDI_X1);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (out_pc !== 64'd0 || out_imm !== 64'd0 || out_rd !== 5'd0) begin errors++; $display("FAIL rst_fields got pc=%h imm=%h rd=%0d exp 0", out_pc, out_imm, out_rd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    // Release reset between edges; the word present at the next edge is the first accepted.
    #2;
    rst = 1'b1;
    present(64'h200, I_ADDI_X1);
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h200) begin errors++; $display("FAIL rst_release got v=%b pc=%h exp v=1 pc=200", out_valid, out_pc); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_addi();
    present(64'h1000, I_ADDI_X1);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_pc !== 64'h1000) begin errors++; $display("FAIL addi_fields got v=%b rd=%0d pc=%h exp v=1 rd=1 pc=1000", out_valid, out_rd, out_pc); end
    checks++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL addi_imm got %h exp ffffffffffffffff", out_imm); end
    checks++; if (out_opcode !== 7'h13 || out_rs1_val !== 64'd0 || out_is_load !== 1'b0) begin errors++; $display("FAIL addi_decode got op=%h rs1v=%h ld=%b exp op=13 rs1v=0 ld=0", out_opcode, out_rs1_val, out_is_load); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got v=%b exp 0", out_valid); end
  endtask

  task automatic test_bypass();
    present(64'h1100, I_ADD_655);
    tick();
    checks++; if (out_rs1_val !== 64'd0 || out_rd !== 5'd6 || out_rs2 !== 5'd5) begin errors++; $display("FAIL byp_reset_x5 got rs1v=%h rd=%0d rs2=%0d exp 0 6 5", out_rs1_val, out_rd, out_rs2); end
    in_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 64'h1111;
    tick();
    present(64'h1104, I_ADD_655);
    wb_data = 64'h1234;
    tick();
    wb_en = 1'b0;
    checks++; if (out_rs1_val !== 64'h1234 || out_rs2_val !== 64'h1234) begin errors++; $display("FAIL byp_on got rs1v=%h rs2v=%h exp 1234", out_rs1_val, out_rs2_val); end
    checks++; if (d2_out_rs1_val !== 64'h1111 || d2_out_rs2_val !== 64'h1111) begin errors++; $display("FAIL byp_off got rs1v=%h rs2v=%h exp 1111", d2_out_rs1_val, d2_out_rs2_val); end
    present(64'h1108, I_ADD_655);
    tick();
    in_valid = 1'b0;
    checks++; if (d2_out_rs1_val !== 64'h1234 || out_pc !== 64'h1108) begin errors++; $display("FAIL byp_written got rs1v=%h pc=%h exp 1234 1108", d2_out_rs1_val, out_pc); end
    tick();
  endtask

  task automatic test_load_use();
    present(64'h2000, I_LD_X7);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_ld_accept got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("FAIL lu_ld_out got v=%b ld=%b rd=%0d exp 1 1 7", out_valid, out_is_load, out_rd); end
    present(64'h2004, I_ADD_871);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready_stall got %b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_bubble got v=%b cnt=%0d exp v=0 cnt=1", out_valid, stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_in_ready_after got %b exp 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2004 || out_rd !== 5'd8 || out_is_load !== 1'b0) begin errors++; $display("FAIL lu_add_issue got v=%b pc=%h rd=%0d exp 1 2004 8", out_valid, out_pc, out_rd); end
    // rd = x0 load: no hazard.
    present(64'h3000, I_LD_X0);
    tick();
    present(64'h3004, I_ADD_871);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h3004 || stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_x0_nobubble got v=%b pc=%h cnt=%0d exp 1 3004 1", out_valid, out_pc, stall_cnt); end
    tick();
  endtask

  task automatic test_backpressure();
    present(64'h4000, I_ADDI_X1);
    tick();
    out_ready = 1'b0;
    present(64'h4004, I_LUI);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got %b exp 0", c, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 64'h4000 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_rd !== 5'd1) begin errors++; $display("FAIL bp_hold cyc%0d got v=%b pc=%h imm=%h rd=%0d", c, out_valid, out_pc, out_imm, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h4004 || out_imm !== 64'h12345000) begin errors++; $display("FAIL bp_next got v=%b pc=%h imm=%h exp 1 4004 12345000", out_valid, out_pc, out_imm); end
    tick();
  endtask

  task automatic test_flush();
    present(64'h5000, I_ADDI_X1);
    tick();
    present(64'h5004, I_LUI);
    flush = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 64'hABCD;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_in_ready got %b exp 1", in_ready); end
    tick();
    flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_kill got v=%b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_never got v=%b exp 0", out_valid); end
    present(64'h5008, I_ADD_11);
    tick();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== 64'hABCD || d2_out_rs2_val !== 64'hABCD || out_pc !== 64'h5008) begin errors++; $display("FAIL fl_wb_kept got rs1v=%h d2rs2v=%h pc=%h exp abcd abcd 5008", out_rs1_val, d2_out_rs2_val, out_pc); end
    tick();
  endtask

  task automatic test_back_to_back_imm();
    present(64'h6000, I_SW);
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h6000 || out_imm !== 64'd12) begin errors++; $display("FAIL imm_sw got v=%b pc=%h imm=%h exp 1 6000 c", out_valid, out_pc, out_imm); end
    present(64'h6004, I_BEQ);
    tick();
    checks++; if (out_pc !== 64'h6004 || out_imm !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL imm_beq got pc=%h imm=%h exp 6004 fffffffffffffffc", out_pc, out_imm); end
    present(64'h6008, I_JAL);
    tick();
    checks++; if (out_pc !== 64'h6008 || out_imm !== 64'd8) begin errors++; $display("FAIL imm_jal got pc=%h imm=%h exp 6008 8", out_pc, out_imm); end
    present(64'h600C, I_LUI);
    tick();
    checks++; if (out_pc !== 64'h600C || out_imm !== 64'h12345000 || out_rd !== 5'd5) begin errors++; $display("FAIL imm_lui got pc=%h imm=%h rd=%0d exp 600c 12345000 5", out_pc, out_imm, out_rd); end
    // x0 write with a same-cycle read of x0: neither forward nor store.
    present(64'h6010, I_ADD_900);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'hDEAD;
    tick();
    wb_en = 1'b0;
    checks++; if (out_rs1_val !== 64'd0 || out_rs2_val !== 64'd0) begin errors++; $display("FAIL x0_same got rs1v=%h rs2v=%h exp 0", out_rs1_val, out_rs2_val); end
    present(64'h6014, I_ADD_900);
    tick();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== 64'd0 || d2_out_rs1_val !== 64'd0 || out_pc !== 64'h6014) begin errors++; $display("FAIL x0_after got rs1v=%h d2=%h pc=%h exp 0 0 6014", out_rs1_val, d2_out_rs1_val, out_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_flush();
    test_back_to_back_imm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64: register/data/PC width; SHALL support 32 and 64.
REQ-002 Parameter NREG, default 32: architectural register count; SHALL support 16 and 32; register index width is 5 regardless.
REQ-003 Parameter WB_BYPASS, default 1: 1 means same-cycle writeback forwards to reads; 0 means no forwarding.
REQ-004 Ports (name direction width meaning):
 clk  in  1  sole clock, rising edge
 rst  in  1  asynchronous, active-low reset
 in_valid  in  1  fetched instruction present
 in_ready  out  1  stage accepts in_pc/in_inst this cycle
 in_pc  in  XLEN  instruction PC
 in_inst  in  32  instruction word
 flush  in  1  kill in-flight and incoming instruction
 wb_en  in  1  register write enable
 wb_addr  in  5  write index
 wb_data  in  XLEN  write data
 out_valid  out  1  ID/EX register holds a valid instruction
 out_ready  in  1  EX consumes the ID/EX register this cycle
 out_pc  out  XLEN; out_opcode  out  7; out_funct3  out  3; out_funct7  out  7
 out_rs1, out_rs2, out_rd  out  5 each; out_rs1_val, out_rs2_val, out_imm  out  XLEN each
 out_is_load  out  1  opcode 0000011
 stall_cnt  out  32  count of load-use bubbles inserted

Function
REQ-005 Regfile: NREG x XLEN, x0 reads 0 and ignores writes, indices >= NREG read 0 and ignore writes; written on rising clk when wb_en.
REQ-006 Reads combinational on in_inst[19:15] and in_inst[24:20]; with WB_BYPASS=1 and wb_en and wb_addr equal to a nonzero read index, that read SHALL return wb_data.
REQ-007 Immediate, sign-extended from bit 31 to XLEN: I for opcodes 0010011, 0000011, 1100111, 0011011; S for 0100011; B for 1100011 with bit 0 = 0; U for 0110111, 0010111 (low 12 bits 0); J for 1101111 with bit 0 = 0; any other opcode gives 0.
REQ-008 uses_rs1 is true for every opcode except 0110111, 0010111, 1101111; uses_rs2 is true only for 0110011, 0111011, 0100011, 1100011.
REQ-009 hazard = in_valid & out_valid & out_is_load & out_rd != 0 & ((uses_rs1 & out_rd == rs1) | (uses_rs2 & out_rd == rs2)).
REQ-010 advance = !out_valid | out_ready.
REQ-011 in_ready = flush | (advance & !hazard); it is combinational.
REQ-012 On a clk edge, the first matching case applies:
 - flush: out_valid <= 0; input discarded.
 - advance & hazard: out_valid <= 0 (bubble); stall_cnt += 1, saturating at 0xFFFFFFFF.
 - advance: out_valid <= in_valid; when in_valid, all out_* fields load from the decoded input.
 - otherwise: all outputs hold.
REQ-013 Latency: an accepted instruction appears on out_* exactly one cycle after acceptance; throughput is 1 per cycle without hazards.
REQ-014 Output fields other than out_valid are don't-care while out_valid = 0; they SHALL NOT change while out_valid = 1 and out_ready = 0.
REQ-015 If flush and wb_en occur in the same cycle, the register write SHALL still occur.

Reset
REQ-016 While rst = 0 (asynchronous), every regfile entry, all out_* fields, out_valid and stall_cnt SHALL be 0; in_ready then equals flush | 1 = 1.
REQ-017 When rst deasserts mid-stream, the first accepted instruction SHALL be the one presented on the first rising edge with rst = 1.

Verification
REQ-018 Stream ADDI x1,x0,-1 (0xFFF00093) then hold out_ready = 1 -> next cycle out_valid = 1, out_rd = 1, out_imm = 0xFFFF_FFFF_FFFF_FFFF (XLEN = 64).
REQ-019 Write wb x5 = 0x1234 and present ADD x6,x5,x5 in the same cycle -> out_rs1_val = out_rs2_val = 0x1234 (WB_BYPASS = 1); with WB_BYPASS = 0 both values are the old x5.
REQ-020 Send LD x7,0(x2), then ADD x8,x7,x1 -> one bubble (out_valid = 0 for 1 cycle), in_ready = 0 for that cycle, stall_cnt = 1, then the ADD issues; the same sequence with rd = x0 gives no bubble.
REQ-021 Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> out_* stable, in_ready = 0; the next instruction appears 1 cycle after out_ready returns to 1.
REQ-022 Flush: assert flush with out_valid = 1 and in_valid = 1 -> next cycle out_valid = 0 and the flushed instruction never appears.
REQ-023 Immediates: SW 0x00A12623 gives imm = 12; BEQ 0xFE000EE3 gives imm = -4; JAL 0x0080006F gives imm = 8; LUI 0x123452B7 gives imm = 0x12345000; write to x0 then read it gives 0.
